// File: rtl/intc_nested_pkg.sv
// Shared types and helpers for the nested interrupt controller.
// Holds the FSM state encoding, default vector map constants and the vector-address function.
// Imported by intc_nested and its sub-module.
package intc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } intc_state_e;

  localparam int unsigned VEC_BASE_DEF   = 513;
  localparam int unsigned VEC_STRIDE_DEF = 20;

  // Full-width vector address; the caller truncates to its address width,
  // which gives the modulo-2^ADDR_W wrap.
  function automatic int unsigned vec_addr_calc(input int unsigned base,
                                                input int unsigned stride,
                                                input int unsigned id);
    return base + id * stride;
  endfunction

endpackage

// File: rtl/intc_nested_if.sv
// Bus between peripheral/CPU side and the interrupt controller.
// master: drives int_e, mask_we, mask_d, int_ack, int_ret; reads status.
// slave : the controller; drives irq, vec_addr, irq_id, pending, in_service, depth, busy.
interface intc_nested_if #(
  parameter int N_CH   = 8,
  parameter int ADDR_W = 10
);
  localparam int IDX_W = $clog2(N_CH);
  localparam int DEP_W = $clog2(N_CH + 1);

  logic [N_CH-1:0]   int_e;
  logic              mask_we;
  logic [N_CH-1:0]   mask_d;
  logic              int_ack;
  logic              int_ret;
  logic              irq;
  logic [ADDR_W-1:0] vec_addr;
  logic [IDX_W-1:0]  irq_id;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   in_service;
  logic [DEP_W-1:0]  depth;
  logic              busy;

  modport master (
    output int_e, mask_we, mask_d, int_ack, int_ret,
    input  irq, vec_addr, irq_id, pending, in_service, depth, busy
  );

  modport slave (
    input  int_e, mask_we, mask_d, int_ack, int_ret,
    output irq, vec_addr, irq_id, pending, in_service, depth, busy
  );
endinterface

// File: rtl/intc_nested_prio_enc.sv
// Lowest-index-first priority encoder (bit 0 wins).
// Ports: i_req request vector; o_oh one-hot of winner; o_idx its index; o_vld any request.
// Purely combinational.
module intc_prio_enc #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_oh,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign o_oh  = i_req & (~i_req + N'(1));
  assign o_vld = |i_req;

endmodule

// File: rtl/intc_nested.sv
// Priority interrupt controller with nested service and per-channel masking (channel 0 highest).
// Ports: clk, reset (async, active-high), intc (slave modport: lines, mask, ack/ret in; irq, vector, status out).
// Macro INTC_NEST_EN enables nesting; undefined, a new irq waits until nothing is in service.
module intc_nested
  import intc_pkg::*;
#(
  parameter int          N_CH       = 8,
  parameter int          ADDR_W     = 10,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  intc_nested_if.slave  intc
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int DEP_W = $clog2(N_CH + 1);

`ifdef INTC_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic [N_CH-1:0]   r_int_e_q;
  logic              r_armed;
  logic [N_CH-1:0]   r_pending;
  logic [N_CH-1:0]   r_enable;
  logic [N_CH-1:0]   r_in_service;
  logic [DEP_W-1:0]  r_depth;
  logic [ADDR_W-1:0] r_vec_addr;
  logic [IDX_W-1:0]  r_irq_id;
  intc_state_e       r_state;
  intc_state_e       w_state_nxt;

  logic [N_CH-1:0]   w_cand_oh, w_cur_oh;
  logic [IDX_W-1:0]  w_cand_idx, w_cur_idx;
  logic              w_cand_vld, w_cur_vld;
  logic              w_irq, w_ack, w_ret;
  logic [N_CH-1:0]   w_rise, w_ack_oh, w_ret_oh;
  logic [N_CH-1:0]   w_pending_nxt, w_in_service_nxt;
  logic [DEP_W-1:0]  w_depth_nxt;

  intc_prio_enc #(.N(N_CH)) u_cand (
    .i_req (r_pending & r_enable),
    .o_oh  (w_cand_oh),
    .o_idx (w_cand_idx),
    .o_vld (w_cand_vld)
  );

  intc_prio_enc #(.N(N_CH)) u_cur (
    .i_req (r_in_service),
    .o_oh  (w_cur_oh),
    .o_idx (w_cur_idx),
    .o_vld (w_cur_vld)
  );

  // irq comes straight from register state so it follows pending/mask/in_service
  // on the cycle they change; the FSM only tracks the request/ack phase.
  assign w_irq = w_cand_vld && (!w_cur_vld || (NEST && (w_cand_idx < w_cur_idx)));
  assign w_ack = intc.int_ack && w_irq;
  assign w_ret = intc.int_ret && w_cur_vld;

  // r_armed drops the first edge after reset so a line held high through
  // reset is not mistaken for a fresh request.
  assign w_rise   = intc.int_e & ~r_int_e_q & {N_CH{r_armed}};
  assign w_ack_oh = w_ack ? w_cand_oh : '0;
  assign w_ret_oh = w_ret ? w_cur_oh  : '0;

  // Rise wins over ack clear; ret clears from pre-edge in_service before ack sets.
  assign w_pending_nxt    = (r_pending & ~w_ack_oh) | w_rise;
  assign w_in_service_nxt = (r_in_service & ~w_ret_oh) | w_ack_oh;

  always_comb begin
    w_depth_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_depth_nxt = w_depth_nxt + DEP_W'(w_in_service_nxt[i]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_irq) w_state_nxt = ASSERT;
      ASSERT:  if (w_ack || !w_irq) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_int_e_q    <= '0;
      r_armed      <= 1'b0;
      r_pending    <= '0;
      r_enable     <= '1;
      r_in_service <= '0;
      r_depth      <= '0;
      r_vec_addr   <= '0;
      r_irq_id     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_int_e_q    <= intc.int_e;
      r_armed      <= 1'b1;
      r_pending    <= w_pending_nxt;
      r_in_service <= w_in_service_nxt;
      r_depth      <= w_depth_nxt;
      if (intc.mask_we) r_enable <= intc.mask_d;
      if (w_ack) begin
        r_irq_id   <= w_cand_idx;
        r_vec_addr <= ADDR_W'(vec_addr_calc(VEC_BASE, VEC_STRIDE, 32'(w_cand_idx)));
      end
    end
  end

  assign intc.irq        = w_irq;
  assign intc.vec_addr   = r_vec_addr;
  assign intc.irq_id     = r_irq_id;
  assign intc.pending    = r_pending;
  assign intc.in_service = r_in_service;
  assign intc.depth      = r_depth;
  assign intc.busy       = |r_in_service;

endmodule

// File: tb/tb_intc_nested.sv
// Directed self-checking bench for intc_nested (8 channels, base 513, stride 20).
// Expectations follow INTC_NEST_EN when it is defined for the build.
module tb_intc_nested;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  intc_nested_if #(.N_CH(8), .ADDR_W(10)) bus ();

  intc_nested #(.N_CH(8), .ADDR_W(10), .VEC_BASE(513), .VEC_STRIDE(20)) dut (
    .clk   (clk),
    .reset (reset),
    .intc  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic rise(input int ch);
    bus.int_e[ch] = 1'b1;
    tick();
    bus.int_e[ch] = 1'b0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic ret();
    bus.int_ret = 1'b1;
    tick();
    bus.int_ret = 1'b0;
  endtask

  task automatic set_mask(input logic [7:0] m);
    bus.mask_we = 1'b1;
    bus.mask_d  = m;
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pending"}, 32'(bus.pending), 0);
    chk({tag, "_insvc"},   32'(bus.in_service), 0);
    chk({tag, "_irq"},     32'(bus.irq), 0);
    chk({tag, "_vec"},     32'(bus.vec_addr), 0);
    chk({tag, "_id"},      32'(bus.irq_id), 0);
    chk({tag, "_depth"},   32'(bus.depth), 0);
    chk({tag, "_busy"},    32'(bus.busy), 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset       = 1'b1;
    bus.int_e   = '0;
    bus.mask_we = 1'b0;
    bus.mask_d  = '0;
    bus.int_ack = 1'b0;
    bus.int_ret = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Single request on channel 3
    rise(3);
    chk("a_irq", 32'(bus.irq), 1);
    chk("a_pend", 32'(bus.pending), 32'h08);
    ack();
    chk("a_vec", 32'(bus.vec_addr), 573);
    chk("a_id", 32'(bus.irq_id), 3);
    chk("a_insvc", 32'(bus.in_service), 32'h08);
    chk("a_depth", 32'(bus.depth), 1);
    chk("a_busy", 32'(bus.busy), 1);
    chk("a_irq_off", 32'(bus.irq), 0);
    chk("a_pend_clr", 32'(bus.pending), 0);
    ret();
    chk("a_ret_insvc", 32'(bus.in_service), 0);
    chk("a_ret_depth", 32'(bus.depth), 0);
    chk("a_ret_busy", 32'(bus.busy), 0);

    // Channel 5 in service, channel 1 arrives
    rise(5);
    ack();
    chk("b_vec5", 32'(bus.vec_addr), 613);
    chk("b_insvc5", 32'(bus.in_service), 32'h20);
    rise(1);
`ifdef INTC_NEST_EN
    chk("b_irq_nest", 32'(bus.irq), 1);
    ack();
    chk("b_vec1", 32'(bus.vec_addr), 533);
    chk("b_id1", 32'(bus.irq_id), 1);
    chk("b_depth2", 32'(bus.depth), 2);
    chk("b_insvc22", 32'(bus.in_service), 32'h22);
    ret();
    chk("b_ret_insvc", 32'(bus.in_service), 32'h20);
    chk("b_ret_depth", 32'(bus.depth), 1);
    ret();
    chk("b_ret2_insvc", 32'(bus.in_service), 0);
`else
    chk("b_irq_flat", 32'(bus.irq), 0);
    ack();
    chk("b_ign_insvc", 32'(bus.in_service), 32'h20);
    chk("b_ign_pend", 32'(bus.pending), 32'h02);
    ret();
    chk("b_ret_irq", 32'(bus.irq), 1);
    ack();
    chk("b_vec1", 32'(bus.vec_addr), 533);
    chk("b_depth1", 32'(bus.depth), 1);
    ret();
`endif

    // Lower priority request waits for return
    rise(1);
    ack();
    rise(6);
    chk("c_irq_hold", 32'(bus.irq), 0);
    ret();
    chk("c_irq_after_ret", 32'(bus.irq), 1);
    ack();
    chk("c_vec6", 32'(bus.vec_addr), 633);
    chk("c_id6", 32'(bus.irq_id), 6);
    ret();
    chk("c_depth0", 32'(bus.depth), 0);

    // Masking gates irq but not pending; ack while irq low is ignored
    set_mask(8'hFB);
    rise(2);
    chk("d_pend", 32'(bus.pending), 32'h04);
    chk("d_irq_masked", 32'(bus.irq), 0);
    ack();
    chk("d_ign_pend", 32'(bus.pending), 32'h04);
    chk("d_ign_insvc", 32'(bus.in_service), 0);
    chk("d_ign_vec", 32'(bus.vec_addr), 633);
    set_mask(8'hFF);
    chk("d_irq_unmask", 32'(bus.irq), 1);
    ack();
    chk("d_insvc", 32'(bus.in_service), 32'h04);
    ret();

    // Rise and ack together on channel 0
    rise(0);
    tick();
    chk("e_irq", 32'(bus.irq), 1);
    bus.int_ack  = 1'b1;
    bus.int_e[0] = 1'b1;
    tick();
    bus.int_ack  = 1'b0;
    bus.int_e[0] = 1'b0;
    chk("e_pend_kept", 32'(bus.pending), 32'h01);
    chk("e_insvc", 32'(bus.in_service), 32'h01);
    chk("e_id0", 32'(bus.irq_id), 0);
    chk("e_vec0", 32'(bus.vec_addr), 513);
    chk("e_irq_off", 32'(bus.irq), 0);
    ret();
    chk("e_irq_again", 32'(bus.irq), 1);
    ack();
    chk("e_pend_clr", 32'(bus.pending), 0);
    chk("e_insvc2", 32'(bus.in_service), 32'h01);

    // Reset mid-service with channel 0 held high
    bus.int_e[0] = 1'b1;
    tick();
    chk("e_pend_pre_rst", 32'(bus.pending), 32'h01);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("e_no_retrig", 32'(bus.pending), 0);
    chk("e_no_retrig_irq", 32'(bus.irq), 0);
    bus.int_e[0] = 1'b0;
    tick();
    bus.int_e[0] = 1'b1;
    tick();
    bus.int_e[0] = 1'b0;
    chk("e_retrig", 32'(bus.pending), 32'h01);
    ack();
    ret();

    // Channel 4 in service, channel 0 arrives
    rise(4);
    ack();
    chk("f_vec4", 32'(bus.vec_addr), 593);
    rise(0);
`ifdef INTC_NEST_EN
    chk("f_irq_nest", 32'(bus.irq), 1);
    ack();
    chk("f_depth2", 32'(bus.depth), 2);
    chk("f_insvc", 32'(bus.in_service), 32'h11);
    ret();
    ret();
    chk("f_insvc0", 32'(bus.in_service), 0);
`else
    chk("f_irq_flat", 32'(bus.irq), 0);
    tick();
    chk("f_irq_flat2", 32'(bus.irq), 0);
    ret();
    chk("f_irq_after_ret", 32'(bus.irq), 1);
    ack();
    chk("f_insvc", 32'(bus.in_service), 32'h01);
    chk("f_depth1", 32'(bus.depth), 1);
    ret();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
